data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning the request/response tag width (ROB index).
REQ-002 SHALL have ports `clk` (in, 1, clock) and `rst` (in, 1); reset is synchronous, active-high.
REQ-003 SHALL have request ports:
  - `req_valid` in 1: request present
  - `req_ready` out 1: request accepted this cycle when both are high
  - `req_store` in 1: 1 = store, 0 = load
  - `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU
  - `req_addr` in 32: byte address
  - `req_wdata` in 32: store data, right-justified
  - `req_tag` in TAG_W
REQ-004 SHALL have response ports:
  - `resp_valid` out 1: one-cycle pulse
  - `resp_tag` out TAG_W
  - `resp_data` out 32: extended load data, 0 for stores
  - `resp_err` out 1: misaligned access
REQ-005 SHALL have `flush` (in 1), which discards all pending load responses.
REQ-006 SHALL have data-memory ports:
  - `mem_free` in 1: memory in ready state
  - `mem_read_valid` in 1: read data valid pulse
  - `mem_o_data` in 32
  - `mem_rw_flag` out 2: bit1 read, bit0 write
  - `mem_addr` out 32
  - `mem_i_data` out 32
  - `mem_mask` out 4: bit0 = bits 7:0

Function
REQ-007 SHALL implement the states IDLE, ISSUE, WAIT_RD, WAIT_WR, and RESP.
REQ-008 `req_ready` SHALL equal (state == IDLE); on acceptance, the controller SHALL latch addr, funct3, wdata, tag, and store, then go to ISSUE, or to RESP when the access is misaligned.
REQ-009 An access SHALL be misaligned when it is H/HU with addr[0]=1, or W with addr[1:0]≠0; the controller then SHALL make no memory access and SHALL give resp_err=1 and resp_data=0.
REQ-010 In ISSUE, `mem_rw_flag` SHALL be 2'b10 (load) or 2'b01 (store) only while mem_free=1; when mem_free=0 the controller SHALL hold in ISSUE with rw_flag=0.
REQ-011 An ISSUE cycle with mem_free=1 SHALL be the acceptance edge; the next state SHALL be WAIT_RD or WAIT_WR, and rw_flag SHALL be 0 in every non-ISSUE state.
REQ-012 `mem_addr`, `mem_i_data`, and `mem_mask` SHALL hold latched values from ISSUE until leaving WAIT_RD/WAIT_WR, because memory samples them at completion.
REQ-013 Store lanes SHALL use off = addr[1:0]:
  - mask SB = 4'b0001<<off, SH = 4'b0011<<off, SW = 4'b1111
  - mem_i_data = wdata << (8*off)
REQ-014 Load extraction SHALL compute sh = mem_o_data >> (8*off):
  - B sign-extends sh[7:0], BU zero-extends sh[7:0]
  - H sign-extends sh[15:0], HU zero-extends sh[15:0]
  - W passes unchanged
  - mem_mask SHALL be 4'b1111 for loads
REQ-015 WAIT_RD SHALL capture the extended data on mem_read_valid=1 and go to RESP.
REQ-016 WAIT_WR SHALL wait for mem_free=1, never in the cycle right after acceptance, then go to RESP.
REQ-017 RESP SHALL drive resp_valid=1 for exactly one cycle with the latched tag, data, and err, then go to IDLE.
  - Minimum latency, request accepted to resp_valid: 3 cycles with memory delay 1.
  - Misaligned latency: 1 cycle.
REQ-018 A `flush` on any cycle for a load in ISSUE (not yet accepted) SHALL return to IDLE without issuing.
REQ-019 A `flush` for a load in WAIT_RD SHALL set a drop flag; the controller still waits for mem_read_valid, then returns to IDLE without resp_valid.
REQ-020 A `flush` for a load in RESP SHALL suppress resp_valid.
REQ-021 Stores SHALL ignore flush, since only committed stores reach this block.
REQ-022 When req_valid and flush are both high in IDLE, the request SHALL NOT be accepted (req_ready=0 while flush=1).
REQ-023 Address arithmetic SHALL be 32-bit with no wrap checks, since memory indexes addr>>2.

Reset
REQ-024 On rst, the controller SHALL go to IDLE and clear the drop flag, with outputs:
  - resp_valid=0, resp_err=0, resp_data=0, resp_tag=0
  - mem_rw_flag=0, mem_addr=0, mem_i_data=0, mem_mask=0
REQ-025 A reset mid-operation SHALL abandon the access with no response; the memory is reset by the same rst.

Structure
REQ-026 The shared package SHALL define Data_Width=32, Addr_Width=32, funct3 load/store codes, and rw_flag encodings READ=2'b10 and WRITE=2'b01.
REQ-027 A combinational sub-module `mem_lane_align` SHALL produce the store mask/data and the load extraction, so the FSM stays in data_mem_ctrl.

Verification
REQ-028 SW addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> mask=1111, resp_data=0xDEADBEEF, resp_err=0.
REQ-029 SB addr=0x21, wdata=0x000000A5 over word 0 -> mask=0010, mem_i_data=0x0000A500; then LB 0x21 -> 0xFFFFFFA5, and LBU 0x21 -> 0x000000A5.
REQ-030 LH addr=0x13 -> resp_valid 1 cycle after acceptance, resp_err=1, mem_rw_flag never nonzero.
REQ-031 A request while mem_free=0 is held for 3 cycles -> controller stays in ISSUE with rw_flag=0, and issues on the first free cycle.
REQ-032 LW, then flush during WAIT_RD -> no resp_valid; req_ready returns 1 the cycle after mem_read_valid; the next LW tag is returned correctly.
REQ-033 rst asserted during WAIT_WR -> all outputs reach their reset values next cycle, and no resp_valid appears.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared widths, funct3 access codes, memory rw_flag encodings and FSM states
// for the data-memory controller.
package data_mem_ctrl_pkg;

  localparam int Data_Width = 32;
  localparam int Addr_Width = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] READ    = 2'b10;
  localparam logic [1:0] WRITE   = 2'b01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    RESP    = 3'd4
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// Byte-lane steering: store mask/data placement and load extraction with
// sign/zero extension. Purely combinational.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [2:0]            funct3,
  input  logic                  store,
  input  logic [1:0]            off,
  input  logic [Data_Width-1:0] wdata,
  input  logic [Data_Width-1:0] rdata,
  output logic [3:0]            mask,
  output logic [Data_Width-1:0] st_data,
  output logic [Data_Width-1:0] ld_data
);

  logic [4:0]            shamt;
  logic [Data_Width-1:0] sh;

  always_comb begin
    shamt   = {off, 3'b000};
    sh      = rdata >> shamt;
    st_data = wdata << shamt;

    // loads always fetch the full word; only stores narrow the mask
    mask = 4'b1111;
    if (store) begin
      case (funct3)
        F3_B:    mask = 4'b0001 << off;
        F3_H:    mask = 4'b0011 << off;
        default: mask = 4'b1111;
      endcase
    end

    case (funct3)
      F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   ld_data = {24'b0, sh[7:0]};
      F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   ld_data = {16'b0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: one outstanding access, misalignment trapping,
// load flush handling and a single-cycle tagged response.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int TAG_W = 4
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [Addr_Width-1:0] req_addr,
  input  logic [Data_Width-1:0] req_wdata,
  input  logic [TAG_W-1:0]      req_tag,
  output logic                  resp_valid,
  output logic [TAG_W-1:0]      resp_tag,
  output logic [Data_Width-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  flush,
  input  logic                  mem_free,
  input  logic                  mem_read_valid,
  input  logic [Data_Width-1:0] mem_o_data,
  output logic [1:0]            mem_rw_flag,
  output logic [Addr_Width-1:0] mem_addr,
  output logic [Data_Width-1:0] mem_i_data,
  output logic [3:0]            mem_mask
);

  state_t                state, state_nx;
  logic [Addr_Width-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [Data_Width-1:0] wdata_q, data_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  store_q, err_q, drop_q, wr_first_q;
  logic                  accept, misaligned, load_flush;
  logic [3:0]            lane_mask;
  logic [Data_Width-1:0] lane_st_data, lane_ld_data;

  assign req_ready  = (state == IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign misaligned = is_misaligned(req_funct3, req_addr[1:0]);
  assign load_flush = flush && !store_q;

  assign resp_tag  = tag_q;
  assign resp_data = data_q;
  assign resp_err  = err_q;

  mem_lane_align u_align (
    .funct3  (funct3_q),
    .store   (store_q),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .rdata   (mem_o_data),
    .mask    (lane_mask),
    .st_data (lane_st_data),
    .ld_data (lane_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      store_q    <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      wr_first_q <= 1'b0;
    end else begin
      state      <= state_nx;
      // memory may still report free in the cycle right after it took a write
      wr_first_q <= (state == ISSUE);
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
        tag_q    <= req_tag;
        store_q  <= req_store;
        err_q    <= misaligned;
        data_q   <= '0;
        drop_q   <= 1'b0;
      end
      if (state == WAIT_RD) begin
        if (flush)          drop_q <= 1'b1;
        if (mem_read_valid) data_q <= lane_ld_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = misaligned ? RESP : ISSUE;
      ISSUE: begin
        if (load_flush)    state_nx = IDLE;
        else if (mem_free) state_nx = store_q ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD: if (mem_read_valid) state_nx = (drop_q || flush) ? IDLE : RESP;
      WAIT_WR: if (mem_free && !wr_first_q) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_rw_flag = RW_NONE;
    mem_addr    = '0;
    mem_i_data  = '0;
    mem_mask    = '0;
    resp_valid  = 1'b0;
    case (state)
      ISSUE, WAIT_RD, WAIT_WR: begin
        mem_addr   = addr_q;
        mem_i_data = lane_st_data;
        mem_mask   = lane_mask;
        if (state == ISSUE && mem_free && !load_flush)
          mem_rw_flag = store_q ? WRITE : READ;
      end
      RESP:    resp_valid = !load_flush;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: behavioural memory with variable
// latency, byte-array reference model, directed cases then random traffic.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr, req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic             flush;
  logic             mem_free, mem_read_valid;
  logic [31:0]      mem_o_data;
  logic [1:0]       mem_rw_flag;
  logic [31:0]      mem_addr, mem_i_data;
  logic [3:0]       mem_mask;

  data_mem_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data), .resp_err(resp_err),
    .flush(flush),
    .mem_free(mem_free), .mem_read_valid(mem_read_valid), .mem_o_data(mem_o_data),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_i_data(mem_i_data), .mem_mask(mem_mask)
  );

  always #5 clk = ~clk;

  // memory model: completes mem_delay cycles after taking a request
  logic        stall, mem_busy, pend_wr;
  int          mem_delay, mem_cnt;
  logic [31:0] mem_words [0:63];

  assign mem_free = !mem_busy && !stall;

  always @(posedge clk) begin
    mem_read_valid <= 1'b0;
    if (rst) begin
      mem_busy   <= 1'b0;
      mem_cnt    <= 0;
      pend_wr    <= 1'b0;
      mem_o_data <= '0;
      for (int i = 0; i < 64; i++) mem_words[i] <= '0;
    end else if (!mem_busy) begin
      if (mem_rw_flag != 2'b00 && mem_free) begin
        if (mem_delay <= 1) begin
          if (mem_rw_flag[0]) begin
            for (int i = 0; i < 4; i++)
              if (mem_mask[i]) mem_words[mem_addr[7:2]][8*i +: 8] <= mem_i_data[8*i +: 8];
          end else begin
            mem_read_valid <= 1'b1;
            mem_o_data     <= mem_words[mem_addr[7:2]];
          end
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= mem_delay - 1;
          pend_wr  <= mem_rw_flag[0];
        end
      end
    end else if (mem_cnt == 1) begin
      mem_busy <= 1'b0;
      if (pend_wr) begin
        for (int i = 0; i < 4; i++)
          if (mem_mask[i]) mem_words[mem_addr[7:2]][8*i +: 8] <= mem_i_data[8*i +: 8];
      end else begin
        mem_read_valid <= 1'b1;
        mem_o_data     <= mem_words[mem_addr[7:2]];
      end
    end else begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] ref_bytes [0:255];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (access_bytes(f3) == 2 && a[0]) || (access_bytes(f3) == 4 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0]  idx;
    logic [31:0] v;
    idx = a[7:0];
    case (f3)
      3'b000: begin v = ref_bytes[idx]; if (v >= 128) v = v + 32'hFFFF_FF00; end
      3'b100: v = ref_bytes[idx];
      3'b001: begin
        v = ref_bytes[idx] + 256 * ref_bytes[idx + 8'd1];
        if (v >= 32768) v = v + 32'hFFFF_0000;
      end
      3'b101: v = ref_bytes[idx] + 256 * ref_bytes[idx + 8'd1];
      default: v = {ref_bytes[idx + 8'd3], ref_bytes[idx + 8'd2], ref_bytes[idx + 8'd1], ref_bytes[idx]};
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    m = 0;
    for (int i = 0; i < access_bytes(f3); i++) m = m | (32'd1 << (int'(a[1:0]) + i));
    return m;
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [TAG_W-1:0] tg,
                         input int stall_n, input int dly);
    logic        exp_err;
    logic [31:0] exp_data, exp_mask;
    logic [1:0]  exp_rw;
    int          cyc, rw_cyc, exp_cyc;
    bit          got;
    exp_err  = ref_misaligned(f3, a);
    exp_data = (st || exp_err) ? 32'd0 : ref_load(f3, a);
    exp_rw   = st ? 2'b01 : 2'b10;
    exp_mask = st ? ref_mask(f3, a) : 32'hF;
    if (exp_err) stall_n = 0;
    if (exp_err)   exp_cyc = 0;
    else if (st)   exp_cyc = ((dly > 2) ? dly : 2) + 1;
    else           exp_cyc = dly + 1;

    mem_delay  = dly;
    stall      = (stall_n > 0);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_tag    = tg;
    #1;
    check("req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < stall_n; i++) begin
      check("stall_rw_flag", mem_rw_flag, 0);
      check("stall_not_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    #1;

    cyc = 0; rw_cyc = -1; got = 0;
    while (!got && cyc < 40) begin
      if (mem_rw_flag !== 2'b00 && rw_cyc < 0) begin
        rw_cyc = cyc;
        check("rw_flag", mem_rw_flag, exp_rw);
        check("mem_mask", mem_mask, exp_mask);
        check("mem_addr", mem_addr, a);
        if (st) check("mem_i_data", mem_i_data, wd << (8 * a[1:0]));
      end
      if (resp_valid === 1'b1) got = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("resp_seen", got, 1);
    check("issue_cycle", rw_cyc, exp_err ? -1 : 0);
    if (got) begin
      check("resp_latency", cyc, exp_cyc);
      check("resp_tag", resp_tag, tg);
      check("resp_data", resp_data, exp_data);
      check("resp_err", resp_err, exp_err);
      @(posedge clk); #1;
      check("resp_one_cycle", resp_valid, 0);
      check("ready_after_resp", req_ready, 1);
    end
    if (st && !exp_err)
      for (int i = 0; i < access_bytes(f3); i++) ref_bytes[a[7:0] + 8'(i)] = wd[8*i +: 8];
  endtask

  logic [2:0] f3_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int          cyc;
    bit          saw;
    logic        r_st;
    logic [31:0] r_addr;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; req_tag = '0; flush = 1'b0; stall = 1'b0; mem_delay = 1;
    ref_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_rw_flag", mem_rw_flag, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_i_data", mem_i_data, 0);
    check("rst_mem_mask", mem_mask, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'd1, 0, 1);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 4'd2, 0, 1);
    run_req(1'b1, 3'b000, 32'h21, 32'h000000A5, 4'd3, 0, 1);
    run_req(1'b0, 3'b000, 32'h21, 32'h0, 4'd4, 0, 1);
    run_req(1'b0, 3'b100, 32'h21, 32'h0, 4'd5, 0, 2);
    run_req(1'b0, 3'b001, 32'h13, 32'h0, 4'd6, 0, 1);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 4'd7, 3, 1);

    // load flushed while waiting for read data
    mem_delay = 3;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_tag = 4'd8;
    #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cyc = 0; saw = 0;
    while (mem_read_valid !== 1'b1 && cyc < 20) begin
      if (resp_valid === 1'b1) saw = 1;
      @(posedge clk); #1;
      cyc++;
    end
    check("flush_rd_valid_seen", mem_read_valid, 1);
    @(posedge clk); #1;
    check("flush_ready_back", req_ready, 1);
    check("flush_no_resp", saw | resp_valid, 0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 4'd9, 0, 1);

    // flush in IDLE blocks acceptance
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_tag = 4'd11;
    flush = 1'b1;
    #1;
    check("flush_idle_ready", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("flush_idle_not_taken", req_ready, 1);
    @(posedge clk); #1;

    // reset while a store waits for memory
    run_req(1'b1, 3'b010, 32'h4, 32'h11223344, 4'd12, 0, 1);
    mem_delay = 3;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30;
    req_wdata = 32'h12345678; req_tag = 4'd10;
    #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstww_resp_valid", resp_valid, 0);
    check("rstww_resp_err", resp_err, 0);
    check("rstww_resp_data", resp_data, 0);
    check("rstww_resp_tag", resp_tag, 0);
    check("rstww_rw_flag", mem_rw_flag, 0);
    check("rstww_mem_addr", mem_addr, 0);
    check("rstww_mem_i_data", mem_i_data, 0);
    check("rstww_mem_mask", mem_mask, 0);
    rst = 1'b0;
    ref_clear();
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid === 1'b1) saw = 1;
      @(posedge clk); #1;
    end
    check("rstww_no_resp", saw, 0);
    check("rstww_ready", req_ready, 1);

    for (int k = 0; k < 60; k++) begin
      r_st   = 1'($urandom_range(0, 1));
      r_addr = $urandom;
      r_addr[7:4] = 4'h0;
      run_req(r_st, f3_codes[$urandom_range(0, r_st ? 2 : 4)], r_addr, $urandom,
              TAG_W'($urandom), $urandom_range(0, 2), $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
